config_loader: RTL and testbench

Sequencer for the serial configuration chain threaded through the fabric's programmable muxes and switch boxes. It accepts configuration words from a host over a valid/ready stream and serialises them into the chain head, driving the chain enable only while bits move. It also supports a non-destructive readback: it circulates the chain tail back into the head for exactly one chain length and returns the captured bits as words. It sits between the host/bitstream interface and the fabric's config_in/config_en/config_out daisy chain, on config_clk.

---
 rtl/config_loader_pkg.sv | 26 ++
 rtl/config_loader.sv | 119 +++++++++++
 tb/tb_config_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/config_loader_pkg.sv
// Shared encodings and sizing helpers for the configuration-chain sequencer.
// The fabric top level reuses these when sizing CHAIN_LEN from the tile count.
package config_loader_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LD_WAIT  = 3'd1,
        ST_LD_SHIFT = 3'd2,
        ST_RD_SHIFT = 3'd3,
        ST_RD_OUT   = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Host words needed to cover the whole chain.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/config_loader.sv
// Serialises host words into the fabric configuration chain and performs a
// non-destructive readback by looping the chain tail into its head.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic              config_clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_read,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              chain_data,
    output logic              chain_en,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(CHAIN_LEN);
    localparam int WW = cnt_width(WORD_W);
    localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
    localparam logic [WW-1:0] WORD_C = WW'(WORD_W);

    state_e            state_q, state_d;
    logic [CW-1:0]     bcnt_q, bcnt_d, bcnt_inc;
    logic [WW-1:0]     wbit_q, wbit_d, wbit_inc;
    logic [WORD_W-1:0] sreg_q, sreg_d;

    assign bcnt_inc = bcnt_q + CW'(1);
    assign wbit_inc = wbit_q + WW'(1);

    always_ff @(posedge config_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            wbit_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wbit_q  <= wbit_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wbit_d  = wbit_q;
        sreg_d  = sreg_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bcnt_d = '0;
                    wbit_d = '0;
                    sreg_d = '0;
                    if (start_load)      state_d = ST_LD_WAIT;
                    else if (start_read) state_d = ST_RD_SHIFT;
                end
                ST_LD_WAIT: begin
                    if (s_valid) begin
                        sreg_d  = s_data;
                        wbit_d  = '0;
                        state_d = ST_LD_SHIFT;
                    end
                end
                ST_LD_SHIFT: begin
                    // Upper bits of a final partial word simply never get shifted out.
                    sreg_d = sreg_q >> 1;
                    bcnt_d = bcnt_inc;
                    wbit_d = wbit_inc;
                    if (bcnt_inc == LEN_C)       state_d = ST_DONE;
                    else if (wbit_inc == WORD_C) state_d = ST_LD_WAIT;
                end
                ST_RD_SHIFT: begin
                    sreg_d = sreg_q | (WORD_W'(chain_tail) << wbit_q);
                    bcnt_d = bcnt_inc;
                    wbit_d = wbit_inc;
                    if (wbit_inc == WORD_C || bcnt_inc == LEN_C) state_d = ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (m_ready) begin
                        if (bcnt_q == LEN_C) begin
                            state_d = ST_DONE;
                        end else begin
                            sreg_d  = '0;
                            wbit_d  = '0;
                            state_d = ST_RD_SHIFT;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state; only the readback loop
    // passes chain_tail straight through to the chain head.
    assign s_ready    = (state_q == ST_LD_WAIT);
    assign m_valid    = (state_q == ST_RD_OUT);
    assign m_data     = m_valid ? sreg_q : '0;
    assign chain_en   = (state_q == ST_LD_SHIFT) || (state_q == ST_RD_SHIFT);
    assign chain_data = (state_q == ST_LD_SHIFT) ? sreg_q[0] :
                        (state_q == ST_RD_SHIFT) ? chain_tail : 1'b0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (16-bit and 10-bit chains) driven
// with random words and back-pressure, checked against a bit-stream model.
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int WW = 8;
    localparam int L0 = 16;
    localparam int L1 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [1:0]           sl, sr, ab, sv, mr;
    logic [1:0][WW-1:0]   sd;
    wire  [1:0][WW-1:0]   md;
    wire  [1:0]           srdy, mv, cd, ce, ct, bsy, dn;
    logic [L0-1:0]        chn0 = '0;
    logic [L1-1:0]        chn1 = '0;
    logic [L0-1:0]        exp_chain [2];
    logic [WW-1:0]        lw [2];
    int                   nvec = 0;
    int                   nerr = 0;

    config_loader #(.CHAIN_LEN(L0), .WORD_W(WW)) u_dut0 (
        .config_clk(clk), .rst_n(rst_n), .start_load(sl[0]), .start_read(sr[0]),
        .abort(ab[0]), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(srdy[0]),
        .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .chain_data(cd[0]),
        .chain_en(ce[0]), .chain_tail(ct[0]), .busy(bsy[0]), .done(dn[0])
    );

    config_loader #(.CHAIN_LEN(L1), .WORD_W(WW)) u_dut1 (
        .config_clk(clk), .rst_n(rst_n), .start_load(sl[1]), .start_read(sr[1]),
        .abort(ab[1]), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(srdy[1]),
        .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .chain_data(cd[1]),
        .chain_en(ce[1]), .chain_tail(ct[1]), .busy(bsy[1]), .done(dn[1])
    );

    // Chains: head enters at the top bit, tail is bit 0; contents survive reset.
    always @(posedge clk) if (ce[0]) chn0 <= {cd[0], chn0[L0-1:1]};
    always @(posedge clk) if (ce[1]) chn1 <= {cd[1], chn1[L1-1:1]};
    assign ct[0] = chn0[0];
    assign ct[1] = chn1[0];

    function automatic int len_of(input int d);
        return (d != 0) ? L1 : L0;
    endfunction

    function automatic int nw_of(input int d);
        return num_words(len_of(d), WW);
    endfunction

    function automatic logic [L0-1:0] chain_of(input int d);
        return (d != 0) ? {{(L0-L1){1'b0}}, chn1} : chn0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input int d, input bit gaps, input bit pulse_read, input bit both_start);
        int k, idx, en_cnt, done_at;
        bit got_done;
        logic [L0-1:0] stream;
        // After a load, chain position i holds bit i of the LSB-first word stream.
        stream = '0;
        for (int j = 0; j < len_of(d); j++) stream[j] = lw[j / WW][j % WW];
        @(negedge clk);
        sl[d] = 1'b1; sr[d] = both_start; sv[d] = 1'b0;
        k = 0; idx = 0; en_cnt = 0; done_at = 0; got_done = 1'b0;
        while (!got_done && k < 400) begin
            @(negedge clk);
            k++;
            sl[d] = 1'b0; sr[d] = 1'b0;
            if (k == 1) chk("ld_ready_on_entry", srdy[d], 1'b1);
            if (ce[d]) en_cnt++;
            if (pulse_read && k == 4) sr[d] = 1'b1;
            if (dn[d]) begin
                got_done = 1'b1;
                done_at  = k;
            end else begin
                sv[d] = (idx < nw_of(d)) && (!gaps || $urandom_range(0, 2) != 0);
                sd[d] = sv[d] ? lw[idx] : WW'($urandom);
                if (srdy[d] && sv[d]) idx++;
            end
        end
        sv[d] = 1'b0;
        chk("ld_done_seen", got_done, 1'b1);
        if (!gaps) chk("ld_done_latency", done_at, len_of(d) + nw_of(d) + 1);
        chk("ld_en_cycles", en_cnt, len_of(d));
        chk("ld_words_taken", idx, nw_of(d));
        chk("ld_chain", chain_of(d), stream);
        exp_chain[d] = stream;
        @(negedge clk);
        chk("ld_idle_after_done", {bsy[d], dn[d], ce[d]}, 3'b000);
    endtask

    // stall0: -1 always ready, 0 random ready, >0 hold m_ready low that many cycles on word 0
    task automatic do_read(input int d, input int stall0);
        int k, idx, en_cnt, held, last_hs;
        bit got_done;
        logic [WW-1:0] ew, first;
        @(negedge clk);
        sr[d] = 1'b1; mr[d] = 1'b0;
        k = 0; idx = 0; en_cnt = 0; held = 0; last_hs = -10; got_done = 1'b0; first = '0;
        while (!got_done && k < 400) begin
            @(negedge clk);
            k++;
            sr[d] = 1'b0;
            if (ce[d]) en_cnt++;
            if (dn[d]) begin
                got_done = 1'b1;
                chk("rd_done_timing", k, last_hs + 1);
            end else if (mv[d]) begin
                chk("rd_en_low_in_out", ce[d], 1'b0);
                if (held == 0) first = md[d];
                else chk("rd_data_stable", md[d], first);
                held++;
                if (stall0 < 0)                    mr[d] = 1'b1;
                else if (stall0 > 0 && idx == 0)   mr[d] = (held > stall0);
                else                               mr[d] = ($urandom_range(0, 1) == 1);
                if (mr[d]) begin
                    ew = '0;
                    for (int b = 0; b < WW; b++)
                        if (idx * WW + b < len_of(d)) ew[b] = exp_chain[d][idx * WW + b];
                    chk("rd_word", md[d], ew);
                    idx++;
                    held = 0;
                    last_hs = k;
                end
            end else begin
                mr[d] = ($urandom_range(0, 1) == 1);
            end
        end
        mr[d] = 1'b0;
        chk("rd_done_seen", got_done, 1'b1);
        chk("rd_words", idx, nw_of(d));
        chk("rd_en_cycles", en_cnt, len_of(d));
        chk("rd_chain_intact", chain_of(d), exp_chain[d]);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++)
            chk(tag, {srdy[d], mv[d], md[d], cd[d], ce[d], bsy[d], dn[d]}, '0);
    endtask

    initial begin
        int sh;
        bit fired;
        rst_n = 1'b0;
        sl = '0; sr = '0; ab = '0; sv = '0; mr = '0; sd = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_outputs");
        rst_n = 1'b1;

        // Directed: both starts together, stray start_read mid-load, full readback.
        lw[0] = 8'hA5; lw[1] = 8'h3C;
        do_load(0, 1'b0, 1'b1, 1'b1);
        do_read(0, -1);
        // Short chain: last word partly unused, readback pads with zeros.
        lw[0] = 8'hFF; lw[1] = 8'hFF;
        do_load(1, 1'b0, 1'b0, 1'b0);
        do_read(1, -1);
        do_read(0, 5);

        // Abort after five shifts.
        lw[0] = WW'($urandom); lw[1] = WW'($urandom);
        @(negedge clk);
        sl[0] = 1'b1;
        sh = 0; fired = 1'b0;
        for (int k = 0; k < 50 && !fired; k++) begin
            @(negedge clk);
            sl[0] = 1'b0; sv[0] = 1'b1; sd[0] = lw[0];
            if (ce[0]) begin
                if (sh == 5) begin
                    ab[0] = 1'b1;
                    fired = 1'b1;
                end
                sh++;
            end
        end
        chk("ab_reached", fired, 1'b1);
        @(negedge clk);
        ab[0] = 1'b0; sv[0] = 1'b0;
        chk("ab_state", {bsy[0], ce[0], dn[0], srdy[0]}, 4'b0000);
        repeat (3) begin
            @(negedge clk);
            chk("ab_no_done", {bsy[0], dn[0]}, 2'b00);
        end

        // Asynchronous reset in the middle of a readback shift.
        @(negedge clk);
        sr[0] = 1'b1;
        @(negedge clk);
        sr[0] = 1'b0;
        @(negedge clk);
        chk("rst_pre_in_shift", ce[0], 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with back-pressure on both chain lengths.
        for (int it = 0; it < 8; it++) begin
            lw[0] = WW'($urandom); lw[1] = WW'($urandom);
            do_load(it % 2, it >= 2, 1'b0, 1'b0);
            do_read(it % 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
